// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the digit-serial multiplier controller.
package mul_seq_pkg;

   localparam int unsigned DIGIT_W = 2;
   localparam int unsigned PP_W    = 2 * DIGIT_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mul2x2_unit.sv
// Combinational 2-bit x 2-bit unsigned multiply unit, shared across all digit pairs.
module mul2x2_unit
   import mul_seq_pkg::*;
(
   input  logic [DIGIT_W-1:0] a_i,
   input  logic [DIGIT_W-1:0] b_i,
   output logic [PP_W-1:0]    prod_c
);

   always_comb begin
      prod_c = PP_W'(a_i) * PP_W'(b_i);
   end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential WIDTH x WIDTH multiplier: one 2x2 digit product accumulated per cycle.
// Optional build macro MUL_SEQ_ZERO_SKIP_EN: zero operands bypass RUN straight to DONE.
module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p
);

   localparam int unsigned DIGITS = WIDTH / 2;
   localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned P_W    = 2 * WIDTH;
   localparam int unsigned SH_W   = $clog2(P_W) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

   if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("mul_seq_ctrl: WIDTH must be even and >= 2");
   end

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   ra_q, ra_d;
   logic [WIDTH-1:0]   rb_q, rb_d;
   logic [P_W-1:0]     acc_q, acc_d;
   logic [P_W-1:0]     p_q, p_d;
   logic [CNT_W-1:0]   i_q, i_d;
   logic [CNT_W-1:0]   j_q, j_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [DIGIT_W-1:0] dig_a_c;
   logic [DIGIT_W-1:0] dig_b_c;
   logic [PP_W-1:0]    pp_c;
   logic [SH_W-1:0]    sh_c;
   logic [P_W-1:0]     pp_sh_c;

   // Digit select and weight of the current digit pair
   always_comb begin
      dig_a_c = DIGIT_W'(ra_q >> {i_q, 1'b0});
      dig_b_c = DIGIT_W'(rb_q >> {j_q, 1'b0});
      sh_c    = (SH_W'(i_q) + SH_W'(j_q)) << 1;
      pp_sh_c = P_W'(pp_c) << sh_c;
   end

   mul2x2_unit u_mul2x2 (
      .a_i    (dig_a_c),
      .b_i    (dig_b_c),
      .prod_c (pp_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         i_q     <= i_d;
         j_q     <= j_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state; busy/done are computed from the state being entered so they register cleanly
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      acc_d   = acc_q;
      p_d     = p_q;
      i_d     = i_q;
      j_d     = j_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = ST_RUN;
               busy_d  = 1'b1;
`ifdef MUL_SEQ_ZERO_SKIP_EN
               if ((a == '0) || (b == '0)) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  p_d     = '0;
               end
`else
`endif
            end
         end

         ST_RUN: begin
            acc_d  = acc_q + pp_sh_c;
            busy_d = 1'b1;
            if (j_q == LAST) begin
               j_d = '0;
               if (i_q == LAST) begin
                  i_d     = '0;
                  p_d     = acc_d;
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  i_d = i_q + CNT_W'(1);
               end
            end else begin
               j_d = j_q + CNT_W'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl at WIDTH = 2, 8 and 16.
module tb_mul_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        s2 = 1'b0, s8 = 1'b0, s16 = 1'b0;
   logic [1:0]  a2 = '0, b2 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy2, busy8, busy16;
   logic        done2, done8, done16;
   logic [3:0]  p2;
   logic [15:0] p8;
   logic [31:0] p16;

   int n_assert = 0;
   int n_fail   = 0;
   int overlap  = 0;

   always #5 clk = ~clk;

   mul_seq_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .p(p2));

   mul_seq_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .p(p8));

   mul_seq_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .p(p16));

   always @(negedge clk) begin
      if ((busy2 === 1'b1 && done2 === 1'b1) || (busy8 === 1'b1 && done8 === 1'b1) ||
          (busy16 === 1'b1 && done16 === 1'b1))
         overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic st, input logic [15:0] aa, input logic [15:0] bb);
      case (sel)
         2:       begin s2 = st;  a2 = 2'(aa);  b2 = 2'(bb);  end
         8:       begin s8 = st;  a8 = 8'(aa);  b8 = 8'(bb);  end
         default: begin s16 = st; a16 = aa;     b16 = bb;     end
      endcase
   endtask

   function automatic logic get_done(input int sel);
      case (sel)
         2:       return done2;
         8:       return done8;
         default: return done16;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         2:       return busy2;
         8:       return busy8;
         default: return busy16;
      endcase
   endfunction

   function automatic logic [31:0] get_p(input int sel);
      case (sel)
         2:       return 32'(p2);
         8:       return 32'(p8);
         default: return p16;
      endcase
   endfunction

   // One start pulse; lat = edges after the start edge until done is seen; ends back in IDLE
   task automatic op(input int sel, input logic [15:0] aa, input logic [15:0] bb,
                     output logic [31:0] prod, output int lat, output int nb);
      drive(sel, 1'b1, aa, bb);
      tick();
      drive(sel, 1'b0, aa, bb);
      lat = 0;
      nb  = 0;
      while (get_done(sel) !== 1'b1 && lat < 200) begin
         if (get_busy(sel) === 1'b1) nb++;
         tick();
         lat++;
      end
      prod = get_p(sel);
      tick();
   endtask

   initial begin
      logic [31:0] prod;
      logic [15:0] ra, rb;
      int lat, nb, gap, ndone;
      int zlat;

`ifdef MUL_SEQ_ZERO_SKIP_EN
      zlat = 0;
`else
      zlat = 16;
`endif

      #2;
      chk("reset_busy", 32'(busy8), 32'd0);
      chk("reset_done", 32'(done8), 32'd0);
      chk("reset_p",    32'(p8),    32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      op(8, 16'h00FF, 16'h00FF, prod, lat, nb);
      chk("max_p",    prod,        32'h0000FE01);
      chk("max_lat",  32'(lat),    32'd16);
      chk("max_busy", 32'(nb),     32'd16);
      chk("max_single_pulse", 32'(done8), 32'd0);
      chk("max_idle_busy",    32'(busy8), 32'd0);
      chk("max_p_held",       32'(p8),    32'h0000FE01);

      op(8, 16'h00B4, 16'h006D, prod, lat, nb);
      chk("mix_p", prod, 32'h00004CA4);

      // Async reset mid-RUN discards the operation
      drive(8, 1'b1, 16'h00FF, 16'h00FF);
      tick();
      drive(8, 1'b0, 16'h00FF, 16'h00FF);
      repeat (5) tick();
      chk("rst_pre_busy", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_busy", 32'(busy8), 32'd0);
      chk("rst_async_done", 32'(done8), 32'd0);
      chk("rst_async_p",    32'(p8),    32'd0);
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 24; k++) begin
         if (done8 === 1'b1) ndone++;
         tick();
      end
      chk("rst_no_done", 32'(ndone), 32'd0);

      // Start held high through RUN and DONE with operands changing
      drive(8, 1'b1, 16'h00B4, 16'h006D);
      tick();
      lat = 0;
      while (done8 !== 1'b1 && lat < 200) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         tick();
         lat++;
      end
      chk("ign_lat", 32'(lat), 32'd16);
      chk("ign_p",   32'(p8),  32'h00004CA4);
      a8 = 8'h01;
      b8 = 8'h80;
      tick();
      chk("ign_idle_busy", 32'(busy8), 32'd0);
      gap = 1;
      while (done8 !== 1'b1 && gap < 200) begin
         tick();
         gap++;
      end
      chk("b2b_gap", 32'(gap), 32'd18);
      chk("b2b_p",   32'(p8),  32'h00000080);
      s8 = 1'b0;
      tick();
      tick();

      op(8, 16'h0000, 16'h005A, prod, lat, nb);
      chk("zero_p",    prod,     32'd0);
      chk("zero_lat",  32'(lat), 32'(zlat));
      chk("zero_busy", 32'(nb),  32'(zlat));

      op(2, 16'h3, 16'h3, prod, lat, nb);
      chk("w2_p",   prod,     32'd9);
      chk("w2_lat", 32'(lat), 32'd1);
      op(2, 16'h2, 16'h3, prod, lat, nb);
      chk("w2_p_b", prod,     32'd6);

      op(16, 16'hFFFF, 16'hFFFF, prod, lat, nb);
      chk("w16_p",    prod,     32'hFFFE0001);
      chk("w16_lat",  32'(lat), 32'd64);
      chk("w16_busy", 32'(nb),  32'd64);

      for (int k = 0; k < 4; k++) begin
         ra = 16'($urandom_range(1, 255));
         rb = 16'($urandom_range(1, 255));
         op(8, ra, rb, prod, lat, nb);
         chk("rand8_p", prod, 32'(ra) * 32'(rb));
         ra = 16'($urandom_range(1, 65535));
         rb = 16'($urandom_range(1, 65535));
         op(16, ra, rb, prod, lat, nb);
         chk("rand16_p", prod, 32'(ra) * 32'(rb));
      end

      chk("busy_done_overlap", 32'(overlap), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
